rl_lj_pair_arbiter: RTL and testbench
=====================================

# rl_lj_pair_arbiter

Round-robin arbiter and sequencer that shares one range-limited LJ force evaluation pipeline between NUM_REQ pair-filter requesters. Issues at most one particle pair per cycle into the pipeline and tags each pair with its requester ID. Tracks the fixed pipeline latency to return each force result with the correct ID. Sits between the pair filters and the LJ pair evaluator; an IDLE/RUN/DRAIN controller lets the top level flush the pipeline at the end of a cell iteration.

## Interface
- NUM_REQ, 4, number of requesters
- ID_WIDTH, 2, requester ID width; 2^ID_WIDTH ≥ NUM_REQ
- DATA_WIDTH, 32, IEEE single-precision word width
- PIPE_LATENCY, 14, cycles from pipe_r2_valid to pipe_force_valid
- CNT_WIDTH, 5, in-flight counter width; must hold PIPE_LATENCY+1
- CUTOFF_2, 32'h43100000, squared cutoff (144.0) used by the optional filter
---
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: IDLE→RUN
- flush  in  1  pulse: RUN→DRAIN
- req_valid  in  NUM_REQ  per-requester pair valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_r2, req_dx, req_dy, req_dz  in  NUM_REQ*DATA_WIDTH each  packed pair data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- pipe_r2_valid  out  1  issue strobe to evaluator
- pipe_r2, pipe_dx, pipe_dy, pipe_dz  out  DATA_WIDTH each  issued pair
- pipe_force_valid  in  1  evaluator result valid
- pipe_force_x, pipe_force_y, pipe_force_z  in  DATA_WIDTH each  evaluator forces
- res_valid  out  1  result strobe
- res_id  out  ID_WIDTH  owning requester
- res_force_x, res_force_y, res_force_z  out  DATA_WIDTH each  forces
- inflight  out  CNT_WIDTH  pairs issued but not yet returned
- busy  out  1  state ≠ IDLE
- drain_done  out  1  one-cycle pulse on DRAIN→IDLE
- tag_error  out  1  sticky tag/valid mismatch flag
- pair_dropped  out  1  one-cycle pulse per filtered pair (0 when filter compiled out)

## Operation
- States: IDLE (no grants); RUN (arbitrate); DRAIN (no grants, wait for inflight==0).
- IDLE + start → RUN. Flush in IDLE is ignored. Start and flush asserted together in IDLE → RUN.
- RUN + flush → DRAIN. Start in RUN/DRAIN is ignored.
- DRAIN with inflight==0 → IDLE and pulse drain_done. A DRAIN entered with inflight already 0 exits on the next cycle.
- Arbitration is combinational in RUN only.
  - Grant the lowest index ≥ rr_ptr (wrapping) with req_valid=1; req_ready is the one-hot grant.
  - On a grant, rr_ptr ← grant+1 mod NUM_REQ. rr_ptr is unchanged with no grant.
  - The flush cycle itself may still grant.
- Handshake = req_valid & req_ready. The granted pair is registered onto the pipe_* outputs with pipe_r2_valid=1 next cycle. Otherwise pipe_r2_valid=0 and the data holds its previous value.
- Tag shift register: PIPE_LATENCY stages of {valid, id}, loaded in parallel with pipe_r2_valid.
- On pipe_force_valid, the next cycle registers res_valid=1, res_id=tail id, and forces passed through unmodified.
- A tail valid ≠ pipe_force_valid sets tag_error, which is cleared only by rst. On a mismatch, res_valid follows pipe_force_valid.
- inflight: +1 on issue, −1 on pipe_force_valid; simultaneous issue and return leave it unchanged. It saturates at 0 (no underflow).
- Reset: all outputs 0, state IDLE, rr_ptr 0, tag register cleared, tag_error 0. Reset mid-operation discards all in-flight tags. The evaluator shares rst, so no stale results return.

## Timing
- Handshake → pipe_r2_valid: 1 cycle.
- pipe_r2_valid → pipe_force_valid: PIPE_LATENCY (external).
- pipe_force_valid → res_valid: 1 cycle.
- Handshake → res_valid: PIPE_LATENCY+2 = 16 cycles at default.
- Throughput: one pair per cycle sustained. No result backpressure; consumers must accept res_valid every cycle.
- req_ready depends combinationally on req_valid, state, and rr_ptr only.

## Configuration
- PAIR_CUTOFF_FILTER_EN defined:
  - A granted pair with r2 > CUTOFF_2 or r2 == 0 (unsigned bit compare; r2 ≥ 0) is accepted but not issued.
  - For a filtered pair: no tag, no inflight change, pair_dropped pulses 1 cycle after the handshake.
  - rr_ptr still advances.
- Undefined: every granted pair is issued and pair_dropped is tied 0.

## Test plan
- Single requester 0 presents r2=0x40800000 (4.0) in RUN → pipe_r2_valid at +1, res_valid with res_id=0 at +16, inflight 1 then back to 0.
- All 4 requesters hold valid for 8 cycles from rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; 8 results in the same order at 16-cycle offset.
- Issue on the same cycle pipe_force_valid returns → inflight unchanged. Flush with inflight=5 → busy until the last result, then drain_done pulses exactly once and state is IDLE.
- Inject a spurious pipe_force_valid with an empty tag register → tag_error=1, held until rst.
- With PAIR_CUTOFF_FILTER_EN, r2=0x43200000 (160.0) and r2=0 → both accepted, pair_dropped pulses, no pipe_r2_valid, inflight stays 0.
- rst asserted with 3 pairs in flight → next cycle all outputs 0, state IDLE; a subsequent start gives a clean run with res_id correct.

Source files
------------

// File: rtl/rl_lj_pair_arbiter.sv
// Round-robin arbiter sharing one LJ pair evaluator between NUM_REQ pair filters, with ID tagging and an IDLE/RUN/DRAIN flush controller.
// Optional feature macro: PAIR_CUTOFF_FILTER_EN drops out-of-range pairs (r2 > CUTOFF_2 or r2 == 0) instead of issuing them.
module rl_lj_pair_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_LATENCY = 14,
    parameter int CNT_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] CUTOFF_2 = 32'h43100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_flush,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_r2,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_dx,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_dy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_dz,
    output logic                          o_pipe_r2_valid,
    output logic [DATA_WIDTH-1:0]         o_pipe_r2,
    output logic [DATA_WIDTH-1:0]         o_pipe_dx,
    output logic [DATA_WIDTH-1:0]         o_pipe_dy,
    output logic [DATA_WIDTH-1:0]         o_pipe_dz,
    input  logic                          i_pipe_force_valid,
    input  logic [DATA_WIDTH-1:0]         i_pipe_force_x,
    input  logic [DATA_WIDTH-1:0]         i_pipe_force_y,
    input  logic [DATA_WIDTH-1:0]         i_pipe_force_z,
    output logic                          o_res_valid,
    output logic [ID_WIDTH-1:0]           o_res_id,
    output logic [DATA_WIDTH-1:0]         o_res_force_x,
    output logic [DATA_WIDTH-1:0]         o_res_force_y,
    output logic [DATA_WIDTH-1:0]         o_res_force_z,
    output logic [CNT_WIDTH-1:0]          o_inflight,
    output logic                          o_busy,
    output logic                          o_drain_done,
    output logic                          o_tag_error,
    output logic                          o_pair_dropped
);

`ifdef PAIR_CUTOFF_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_drain_done;
    logic [ID_WIDTH-1:0]     r_rr_ptr;
    logic [CNT_WIDTH-1:0]    r_inflight;

    logic                    r_pipe_valid;
    logic [ID_WIDTH-1:0]     r_pipe_id;
    logic [DATA_WIDTH-1:0]   r_pipe_r2;
    logic [DATA_WIDTH-1:0]   r_pipe_dx;
    logic [DATA_WIDTH-1:0]   r_pipe_dy;
    logic [DATA_WIDTH-1:0]   r_pipe_dz;
    logic                    r_pair_dropped;

    logic [PIPE_LATENCY-1:0]               r_tag_valid;
    logic [PIPE_LATENCY-1:0][ID_WIDTH-1:0] r_tag_id;

    logic                    r_res_valid;
    logic [ID_WIDTH-1:0]     r_res_id;
    logic [DATA_WIDTH-1:0]   r_res_force_x;
    logic [DATA_WIDTH-1:0]   r_res_force_y;
    logic [DATA_WIDTH-1:0]   r_res_force_z;
    logic                    r_tag_error;

    logic [NUM_REQ-1:0]      w_grant;
    logic                    w_grant_any;
    logic [ID_WIDTH-1:0]     w_grant_id;
    logic [DATA_WIDTH-1:0]   w_sel_r2;
    logic [DATA_WIDTH-1:0]   w_sel_dx;
    logic [DATA_WIDTH-1:0]   w_sel_dy;
    logic [DATA_WIDTH-1:0]   w_sel_dz;
    int                      w_slot_sum;
    logic [ID_WIDTH-1:0]     w_slot;
    logic                    w_out_of_range;
    logic                    w_filtered;
    logic                    w_issue;
    logic                    w_tail_valid;
    logic [ID_WIDTH-1:0]     w_tail_id;

    // Scan from rr_ptr upward with wrap; the first valid requester wins and its data is muxed out.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_sel_r2    = '0;
        w_sel_dx    = '0;
        w_sel_dy    = '0;
        w_sel_dz    = '0;
        w_slot_sum  = 0;
        w_slot      = '0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_slot_sum = (int'(r_rr_ptr) + k) % NUM_REQ;
                w_slot     = ID_WIDTH'(w_slot_sum);
                if (!w_grant_any && i_req_valid[w_slot]) begin
                    w_grant_any      = 1'b1;
                    w_grant[w_slot]  = 1'b1;
                    w_grant_id       = w_slot;
                    w_sel_r2         = i_req_r2[w_slot*DATA_WIDTH +: DATA_WIDTH];
                    w_sel_dx         = i_req_dx[w_slot*DATA_WIDTH +: DATA_WIDTH];
                    w_sel_dy         = i_req_dy[w_slot*DATA_WIDTH +: DATA_WIDTH];
                    w_sel_dz         = i_req_dz[w_slot*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // r2 is non-negative, so an unsigned compare of the float bits orders it correctly.
    assign w_out_of_range = (w_sel_r2 > CUTOFF_2) || (w_sel_r2 == '0);
    assign w_filtered     = FILTER_EN && w_out_of_range;
    assign w_issue        = w_grant_any && !w_filtered;

    assign w_tail_valid   = r_tag_valid[PIPE_LATENCY-1];
    assign w_tail_id      = r_tag_id[PIPE_LATENCY-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_drain_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Filtered pairs still count as served for fairness, so the pointer moves on any grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr       <= '0;
            r_pipe_valid   <= 1'b0;
            r_pipe_id      <= '0;
            r_pipe_r2      <= '0;
            r_pipe_dx      <= '0;
            r_pipe_dy      <= '0;
            r_pipe_dz      <= '0;
            r_pair_dropped <= 1'b0;
        end else begin
            if (w_grant_any) begin
                r_rr_ptr <= ID_WIDTH'((int'(w_grant_id) + 1) % NUM_REQ);
            end
            r_pipe_valid   <= w_issue;
            r_pair_dropped <= w_grant_any && w_filtered;
            if (w_issue) begin
                r_pipe_id <= w_grant_id;
                r_pipe_r2 <= w_sel_r2;
                r_pipe_dx <= w_sel_dx;
                r_pipe_dy <= w_sel_dy;
                r_pipe_dz <= w_sel_dz;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else if (w_issue && !i_pipe_force_valid) begin
            r_inflight <= r_inflight + CNT_WIDTH'(1);
        end else if (!w_issue && i_pipe_force_valid && (r_inflight != '0)) begin
            r_inflight <= r_inflight - CNT_WIDTH'(1);
        end
    end

    // The tag chain follows the issued pair through the evaluator so its tail lines up with the returning force.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_valid <= '0;
            r_tag_id    <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[PIPE_LATENCY-2:0], r_pipe_valid};
            r_tag_id    <= {r_tag_id[PIPE_LATENCY-2:0], r_pipe_id};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid   <= 1'b0;
            r_res_id      <= '0;
            r_res_force_x <= '0;
            r_res_force_y <= '0;
            r_res_force_z <= '0;
            r_tag_error   <= 1'b0;
        end else begin
            r_res_valid <= i_pipe_force_valid;
            if (i_pipe_force_valid) begin
                r_res_id      <= w_tail_id;
                r_res_force_x <= i_pipe_force_x;
                r_res_force_y <= i_pipe_force_y;
                r_res_force_z <= i_pipe_force_z;
            end
            if (w_tail_valid != i_pipe_force_valid) begin
                r_tag_error <= 1'b1;
            end
        end
    end

    assign o_req_ready     = w_grant;
    assign o_pipe_r2_valid = r_pipe_valid;
    assign o_pipe_r2       = r_pipe_r2;
    assign o_pipe_dx       = r_pipe_dx;
    assign o_pipe_dy       = r_pipe_dy;
    assign o_pipe_dz       = r_pipe_dz;
    assign o_res_valid     = r_res_valid;
    assign o_res_id        = r_res_id;
    assign o_res_force_x   = r_res_force_x;
    assign o_res_force_y   = r_res_force_y;
    assign o_res_force_z   = r_res_force_z;
    assign o_inflight      = r_inflight;
    assign o_busy          = r_busy;
    assign o_drain_done    = r_drain_done;
    assign o_tag_error     = r_tag_error;
    assign o_pair_dropped  = r_pair_dropped;

endmodule

// File: tb/tb_rl_lj_pair_arbiter.sv
// Directed bench for rl_lj_pair_arbiter with a 14-cycle evaluator model; honours PAIR_CUTOFF_FILTER_EN when defined.
module tb_rl_lj_pair_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int LAT = 14;

    logic clk = 1'b0;
    logic rst, start, flush;
    logic [NR-1:0] reqValid, reqReady;
    logic [NR*DW-1:0] reqR2, reqDx, reqDy, reqDz;
    logic pipeR2Valid;
    logic [DW-1:0] pipeR2, pipeDx, pipeDy, pipeDz;
    logic forceValid, injectForce;
    logic [DW-1:0] forceX, forceY, forceZ;
    logic resValid;
    logic [1:0] resId;
    logic [DW-1:0] resForceX, resForceY, resForceZ;
    logic [4:0] inflight;
    logic busy, drainDone, tagError, pairDropped;

    int testsRun = 0;
    int testsFailed = 0;

    logic [LAT-1:0] evalValid;
    logic [DW-1:0] evalX [LAT];
    logic [DW-1:0] evalY [LAT];
    logic [DW-1:0] evalZ [LAT];

    always #5 clk = ~clk;

    rl_lj_pair_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush),
        .i_req_valid(reqValid), .o_req_ready(reqReady),
        .i_req_r2(reqR2), .i_req_dx(reqDx), .i_req_dy(reqDy), .i_req_dz(reqDz),
        .o_pipe_r2_valid(pipeR2Valid), .o_pipe_r2(pipeR2), .o_pipe_dx(pipeDx),
        .o_pipe_dy(pipeDy), .o_pipe_dz(pipeDz),
        .i_pipe_force_valid(forceValid), .i_pipe_force_x(forceX),
        .i_pipe_force_y(forceY), .i_pipe_force_z(forceZ),
        .o_res_valid(resValid), .o_res_id(resId), .o_res_force_x(resForceX),
        .o_res_force_y(resForceY), .o_res_force_z(resForceZ),
        .o_inflight(inflight), .o_busy(busy), .o_drain_done(drainDone),
        .o_tag_error(tagError), .o_pair_dropped(pairDropped)
    );

    // Evaluator stand-in: fixed latency, echoes dx/dy and scrambles dz so each force lane is distinguishable.
    always @(posedge clk) begin
        if (rst) begin
            evalValid <= '0;
            for (int i = 0; i < LAT; i++) begin
                evalX[i] <= '0;
                evalY[i] <= '0;
                evalZ[i] <= '0;
            end
        end else begin
            evalValid <= {evalValid[LAT-2:0], pipeR2Valid};
            evalX[0] <= pipeDx;
            evalY[0] <= pipeDy;
            evalZ[0] <= pipeDz;
            for (int i = 1; i < LAT; i++) begin
                evalX[i] <= evalX[i-1];
                evalY[i] <= evalY[i-1];
                evalZ[i] <= evalZ[i-1];
            end
        end
    end

    assign forceValid = evalValid[LAT-1] | injectForce;
    assign forceX = evalX[LAT-1];
    assign forceY = evalY[LAT-1];
    assign forceZ = evalZ[LAT-1] ^ 32'hFFFF0000;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int idx, input logic [DW-1:0] r2, input logic [DW-1:0] dx);
        reqR2[idx*DW +: DW] = r2;
        reqDx[idx*DW +: DW] = dx;
        reqDy[idx*DW +: DW] = dx + 32'd1;
        reqDz[idx*DW +: DW] = dx + 32'd2;
    endtask

    task automatic doReset();
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        reqValid = '0;
        injectForce = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        injectForce = 1'b0;
        reqValid = 4'hF;
        reqR2 = '0; reqDx = '0; reqDy = '0; reqDz = '0;
        tick();
        tick();
        testsRun++; if (reqReady !== 4'h0) begin testsFailed++; $display("[TB] FAIL resetReady: got %0h expected 0", reqReady); end
        testsRun++; if (pipeR2Valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL resetPipeValid: got %0b expected 0", pipeR2Valid); end
        testsRun++; if (pipeR2 !== 32'h0) begin testsFailed++; $display("[TB] FAIL resetPipeR2: got %0h expected 0", pipeR2); end
        testsRun++; if (resValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL resetResValid: got %0b expected 0", resValid); end
        testsRun++; if (inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL resetInflight: got %0d expected 0", inflight); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL resetBusy: got %0b expected 0", busy); end
        testsRun++; if (drainDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL resetDrainDone: got %0b expected 0", drainDone); end
        testsRun++; if (tagError !== 1'b0) begin testsFailed++; $display("[TB] FAIL resetTagError: got %0b expected 0", tagError); end
        testsRun++; if (pairDropped !== 1'b0) begin testsFailed++; $display("[TB] FAIL resetPairDropped: got %0b expected 0", pairDropped); end
        rst = 1'b0;
        #1;
        testsRun++; if (reqReady !== 4'h0) begin testsFailed++; $display("[TB] FAIL idleNoGrant: got %0h expected 0", reqReady); end
        reqValid = '0;
    endtask

    task automatic test_start_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flushInIdle: busy got %0b expected 0", busy); end
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL startFlushBusy: got %0b expected 1", busy); end
        setReq(0, 32'h40800000, 32'h11);
        reqValid = 4'b0001;
        #1;
        testsRun++; if (reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL startFlushIsRun: ready got %0h expected 1", reqReady); end
        reqValid = '0;
    endtask

    task automatic test_single();
        int lat;
        doReset();
        doStart();
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL singleBusy: got %0b expected 1", busy); end
        setReq(0, 32'h40800000, 32'h3F800000);
        reqValid = 4'b0001;
        #1;
        testsRun++; if (reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL singleReady: got %0h expected 1", reqReady); end
        tick();
        reqValid = '0;
        testsRun++; if (pipeR2Valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL singleIssue: got %0b expected 1", pipeR2Valid); end
        testsRun++; if (pipeR2 !== 32'h40800000) begin testsFailed++; $display("[TB] FAIL singlePipeR2: got %0h expected 40800000", pipeR2); end
        testsRun++; if (inflight !== 5'd1) begin testsFailed++; $display("[TB] FAIL singleInflight1: got %0d expected 1", inflight); end
        tick();
        lat = 2;
        testsRun++; if (pipeR2Valid !== 1'b0 || pipeDx !== 32'h3F800000) begin testsFailed++; $display("[TB] FAIL singleHold: valid %0b dx %0h expected 0 3f800000", pipeR2Valid, pipeDx); end
        while (!resValid && lat < 40) begin
            tick();
            lat++;
        end
        testsRun++; if (lat !== 16) begin testsFailed++; $display("[TB] FAIL singleLatency: got %0d expected 16", lat); end
        testsRun++; if (resId !== 2'd0) begin testsFailed++; $display("[TB] FAIL singleResId: got %0d expected 0", resId); end
        testsRun++; if (resForceX !== 32'h3F800000) begin testsFailed++; $display("[TB] FAIL singleForceX: got %0h expected 3f800000", resForceX); end
        testsRun++; if (resForceY !== 32'h3F800001) begin testsFailed++; $display("[TB] FAIL singleForceY: got %0h expected 3f800001", resForceY); end
        testsRun++; if (resForceZ !== 32'hC07F0002) begin testsFailed++; $display("[TB] FAIL singleForceZ: got %0h expected c07f0002", resForceZ); end
        testsRun++; if (inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL singleInflight0: got %0d expected 0", inflight); end
    endtask

    task automatic test_round_robin();
        logic expRes;
        int expId;
        doReset();
        doStart();
        for (int i = 0; i < NR; i++) setReq(i, 32'h40800000, 32'hA0 + i);
        for (int t = 0; t < 26; t++) begin
            if (t < 8) begin
                reqValid = 4'hF;
                #1;
                testsRun++; if (reqReady !== 4'(1 << (t % 4))) begin testsFailed++; $display("[TB] FAIL rrGrant%0d: got %0h expected %0h", t, reqReady, 4'(1 << (t % 4))); end
            end else begin
                reqValid = '0;
            end
            tick();
            testsRun++; if (pipeR2Valid !== (t < 8)) begin testsFailed++; $display("[TB] FAIL rrIssue%0d: got %0b expected %0b", t, pipeR2Valid, (t < 8)); end
            if (t < 8) begin
                testsRun++; if (pipeDx !== 32'(32'hA0 + t % 4)) begin testsFailed++; $display("[TB] FAIL rrPipeDx%0d: got %0h expected %0h", t, pipeDx, 32'hA0 + t % 4); end
            end
            if (t == 7) begin
                testsRun++; if (inflight !== 5'd8) begin testsFailed++; $display("[TB] FAIL rrInflight8: got %0d expected 8", inflight); end
            end
            expRes = (t + 1 >= 16) && (t + 1 <= 23);
            testsRun++; if (resValid !== expRes) begin testsFailed++; $display("[TB] FAIL rrResValid%0d: got %0b expected %0b", t + 1, resValid, expRes); end
            if (expRes) begin
                expId = (t + 1 - 16) % 4;
                testsRun++; if (resId !== 2'(expId) || resForceX !== 32'(32'hA0 + expId)) begin testsFailed++; $display("[TB] FAIL rrResult%0d: id %0d x %0h expected %0d %0h", t + 1, resId, resForceX, expId, 32'hA0 + expId); end
            end
        end
        testsRun++; if (inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL rrInflightEnd: got %0d expected 0", inflight); end
    endtask

    task automatic test_back_to_back();
        setReq(1, 32'h40800000, 32'hB1);
        reqValid = 4'b0010;
        tick();
        reqValid = '0;
        for (int i = 0; i < 14; i++) tick();
        reqValid = 4'b0010;
        #1;
        testsRun++; if (forceValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2bModelReturn: got %0b expected 1", forceValid); end
        tick();
        reqValid = '0;
        testsRun++; if (inflight !== 5'd1) begin testsFailed++; $display("[TB] FAIL b2bInflight: got %0d expected 1", inflight); end
        testsRun++; if (resValid !== 1'b1 || pipeR2Valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2bStrobes: res %0b pipe %0b expected 1 1", resValid, pipeR2Valid); end
        for (int i = 0; i < 15; i++) tick();
        testsRun++; if (resValid !== 1'b1 || resId !== 2'd1 || inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL b2bSecond: res %0b id %0d inflight %0d expected 1 1 0", resValid, resId, inflight); end
    endtask

    task automatic test_flush_drain();
        int drainTick;
        int pulses;
        drainTick = -1;
        pulses = 0;
        reqValid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            flush = (t == 4);
            tick();
        end
        flush = 1'b0;
        testsRun++; if (inflight !== 5'd5 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL flushInflight5: inflight %0d busy %0b expected 5 1", inflight, busy); end
        #1;
        testsRun++; if (reqReady !== 4'h0) begin testsFailed++; $display("[TB] FAIL drainNoGrant: got %0h expected 0", reqReady); end
        for (int t = 6; t <= 30; t++) begin
            tick();
            if (t == 16) begin
                testsRun++; if (resValid !== 1'b1 || resId !== 2'd2) begin testsFailed++; $display("[TB] FAIL drainFirstRes: valid %0b id %0d expected 1 2", resValid, resId); end
            end
            if (t == 20) begin
                testsRun++; if (resValid !== 1'b1 || resId !== 2'd2 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL drainLastRes: valid %0b id %0d busy %0b expected 1 2 1", resValid, resId, busy); end
            end
            if (drainDone) begin
                pulses++;
                if (drainTick < 0) drainTick = t;
            end
        end
        reqValid = '0;
        testsRun++; if (drainTick !== 21) begin testsFailed++; $display("[TB] FAIL drainDoneTick: got %0d expected 21", drainTick); end
        testsRun++; if (pulses !== 1) begin testsFailed++; $display("[TB] FAIL drainDonePulses: got %0d expected 1", pulses); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL drainIdle: busy got %0b expected 0", busy); end
    endtask

    task automatic test_tag_error();
        injectForce = 1'b1;
        tick();
        injectForce = 1'b0;
        testsRun++; if (tagError !== 1'b1) begin testsFailed++; $display("[TB] FAIL tagErrorSet: got %0b expected 1", tagError); end
        testsRun++; if (resValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL tagErrorResValid: got %0b expected 1", resValid); end
        testsRun++; if (inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL tagErrorNoUnderflow: got %0d expected 0", inflight); end
        for (int i = 0; i < 3; i++) tick();
        testsRun++; if (tagError !== 1'b1 || resValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL tagErrorSticky: err %0b res %0b expected 1 0", tagError, resValid); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        doStart();
        reqValid = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        reqValid = '0;
        tick();
        tick();
        testsRun++; if (inflight !== 5'd3) begin testsFailed++; $display("[TB] FAIL midInflight3: got %0d expected 3", inflight); end
        rst = 1'b1;
        reqValid = 4'hF;
        tick();
        #1;
        testsRun++; if (busy !== 1'b0 || inflight !== 5'd0 || tagError !== 1'b0) begin testsFailed++; $display("[TB] FAIL midResetState: busy %0b inflight %0d err %0b expected 0 0 0", busy, inflight, tagError); end
        testsRun++; if (pipeR2Valid !== 1'b0 || pipeR2 !== 32'h0 || resValid !== 1'b0 || reqReady !== 4'h0) begin testsFailed++; $display("[TB] FAIL midResetOutputs: pv %0b r2 %0h rv %0b rdy %0h expected 0 0 0 0", pipeR2Valid, pipeR2, resValid, reqReady); end
        rst = 1'b0;
        reqValid = '0;
        doStart();
        setReq(2, 32'h40800000, 32'hC2);
        reqValid = 4'b0100;
        tick();
        reqValid = '0;
        lat = 1;
        while (!resValid && lat < 40) begin
            tick();
            lat++;
        end
        testsRun++; if (lat !== 16 || resId !== 2'd2 || resForceX !== 32'hC2) begin testsFailed++; $display("[TB] FAIL midCleanRun: lat %0d id %0d x %0h expected 16 2 c2", lat, resId, resForceX); end
        testsRun++; if (tagError !== 1'b0) begin testsFailed++; $display("[TB] FAIL midNoTagError: got %0b expected 0", tagError); end
    endtask

    task automatic test_filter();
`ifdef PAIR_CUTOFF_FILTER_EN
        setReq(3, 32'h43200000, 32'hD3);
        reqValid = 4'b1000;
        #1;
        testsRun++; if (reqReady !== 4'b1000) begin testsFailed++; $display("[TB] FAIL filterFarReady: got %0h expected 8", reqReady); end
        tick();
        reqValid = '0;
        testsRun++; if (pairDropped !== 1'b1 || pipeR2Valid !== 1'b0 || inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL filterFar: drop %0b pv %0b inflight %0d expected 1 0 0", pairDropped, pipeR2Valid, inflight); end
        setReq(0, 32'h0, 32'hD0);
        reqValid = 4'b0001;
        #1;
        testsRun++; if (reqReady !== 4'b0001) begin testsFailed++; $display("[TB] FAIL filterZeroReady: got %0h expected 1", reqReady); end
        tick();
        reqValid = '0;
        testsRun++; if (pairDropped !== 1'b1 || pipeR2Valid !== 1'b0 || inflight !== 5'd0) begin testsFailed++; $display("[TB] FAIL filterZero: drop %0b pv %0b inflight %0d expected 1 0 0", pairDropped, pipeR2Valid, inflight); end
        setReq(1, 32'h43100000, 32'hD1);
        reqValid = 4'b0010;
        tick();
        reqValid = '0;
        testsRun++; if (pairDropped !== 1'b0 || pipeR2Valid !== 1'b1 || inflight !== 5'd1) begin testsFailed++; $display("[TB] FAIL filterAtCutoff: drop %0b pv %0b inflight %0d expected 0 1 1", pairDropped, pipeR2Valid, inflight); end
        for (int i = 0; i < 15; i++) tick();
        testsRun++; if (resValid !== 1'b1 || resId !== 2'd1) begin testsFailed++; $display("[TB] FAIL filterAtCutoffRes: valid %0b id %0d expected 1 1", resValid, resId); end
`else
        setReq(3, 32'h43200000, 32'hD3);
        reqValid = 4'b1000;
        tick();
        reqValid = '0;
        testsRun++; if (pairDropped !== 1'b0 || pipeR2Valid !== 1'b1 || pipeR2 !== 32'h43200000 || inflight !== 5'd1) begin testsFailed++; $display("[TB] FAIL noFilterIssue: drop %0b pv %0b r2 %0h inflight %0d expected 0 1 43200000 1", pairDropped, pipeR2Valid, pipeR2, inflight); end
        for (int i = 0; i < 15; i++) tick();
        testsRun++; if (resValid !== 1'b1 || resId !== 2'd3 || pairDropped !== 1'b0) begin testsFailed++; $display("[TB] FAIL noFilterRes: valid %0b id %0d drop %0b expected 1 3 0", resValid, resId, pairDropped); end
`endif
    endtask

    initial begin
        test_reset();
        test_start_flush();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_flush_drain();
        test_tag_error();
        test_reset_midflight();
        test_filter();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
